// File: rtl/aes_subkey_pipe.sv
// aes_subkey_pipe: SubBytes on a 128-bit AES state plus one key-schedule step, computed at the
// input and carried through PIPE_DEPTH lockstep register stages with valid/ready flow control.
// RCON_AUTO=0 takes the round constant from rcon_in; RCON_AUTO=1 uses an internal Rcon counter.
// Optional build macro AES_INV_SBOX_EN adds inv_in, which selects the inverse S-box for the state
// path only. The key path always uses the forward S-box.
module aes_subkey_pipe #(
  parameter int unsigned PIPE_DEPTH = 2,  // legal 1..4
  parameter int unsigned RCON_AUTO  = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  input  logic         rcon_restart,
`ifdef AES_INV_SBOX_EN
  input  logic         inv_in,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [127:0] key_out,
  output logic [7:0]   rcon_out
);

  // Byte x of each table sits at bits [2047-8x -: 8].
  localparam logic [2047:0] SboxFwd = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [10:0] top;
    top = ~{x, 3'b000};  // 2047 - 8x
    return SboxFwd[top -: 8];
  endfunction

`ifdef AES_INV_SBOX_EN
  localparam logic [2047:0] SboxInv = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [10:0] top;
    top = ~{x, 3'b000};
    return SboxInv[top -: 8];
  endfunction
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic         advance;
  logic         accept;
  logic [7:0]   rcon_use;
  logic [7:0]   rcon_cnt_q;
  logic [7:0]   rcon_cnt_d;
  logic [31:0]  rot_w3;
  logic [31:0]  t_word;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] state_sub;
  logic [127:0] key_next;

  logic         vld_q [PIPE_DEPTH];
  logic [127:0] st_q  [PIPE_DEPTH];
  logic [127:0] key_q [PIPE_DEPTH];
  logic [7:0]   rc_q  [PIPE_DEPTH];

  // Flow control: every stage moves together whenever the output slot is free or being taken.
  always_comb begin
    advance = out_ready || !out_valid;
    accept  = in_valid && advance;
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[PIPE_DEPTH-1];
  assign state_out = st_q[PIPE_DEPTH-1];
  assign key_out   = key_q[PIPE_DEPTH-1];
  assign rcon_out  = rc_q[PIPE_DEPTH-1];

  // Round-constant selection and the counter's successor (0x36 wraps back to 0x01).
  always_comb begin
    rcon_use = rcon_in;
    if (RCON_AUTO != 0) begin
      rcon_use = rcon_restart ? 8'h01 : rcon_cnt_q;
    end
    rcon_cnt_d = (rcon_use == 8'h36) ? 8'h01 : xtime(rcon_use);
  end

  // Rcon counter: moves only on accepted beats.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rcon_cnt_q <= 8'h01;
    end else if (accept) begin
      rcon_cnt_q <= rcon_cnt_d;
    end
  end

  // One key-schedule step and per-byte SubBytes on the incoming beat.
  always_comb begin
    rot_w3 = {key_in[23:0], key_in[31:24]};
    t_word = {sbox_fwd(rot_w3[31:24]), sbox_fwd(rot_w3[23:16]),
              sbox_fwd(rot_w3[15:8]), sbox_fwd(rot_w3[7:0])} ^ {rcon_use, 24'h0};
    nw0 = key_in[127:96] ^ t_word;
    nw1 = key_in[95:64] ^ nw0;
    nw2 = key_in[63:32] ^ nw1;
    nw3 = key_in[31:0] ^ nw2;
    key_next = {nw0, nw1, nw2, nw3};
    state_sub = '0;
    for (int b = 0; b < 16; b++) begin
`ifdef AES_INV_SBOX_EN
      state_sub[8*b +: 8] = inv_in ? sbox_inv(state_in[8*b +: 8]) : sbox_fwd(state_in[8*b +: 8]);
`else
      state_sub[8*b +: 8] = sbox_fwd(state_in[8*b +: 8]);
`endif
    end
  end

  // Stage registers: load stage 0 from the input, shift the rest; bubbles travel as-is.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
        vld_q[i] <= 1'b0;
        st_q[i]  <= '0;
        key_q[i] <= '0;
        rc_q[i]  <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      st_q[0]  <= state_sub;
      key_q[0] <= key_next;
      rc_q[0]  <= xtime(rcon_use);
      for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        st_q[i]  <= st_q[i-1];
        key_q[i] <= key_q[i-1];
        rc_q[i]  <= rc_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_aes_subkey_pipe.sv
// Bench for aes_subkey_pipe: two instances (external and automatic Rcon) share one stimulus
// stream; a scoreboard queue holds the expected outputs of both for every accepted beat.
module tb_aes_subkey_pipe;

  localparam int unsigned Depth = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] state_in = '0;
  logic [127:0] key_in = '0;
  logic [7:0]   rcon_in = '0;
  logic         rcon_restart = 1'b0;
  logic         out_ready = 1'b1;
`ifdef AES_INV_SBOX_EN
  logic         inv_in = 1'b0;
`endif

  logic         in_ready0, in_ready1, ov0, ov1;
  logic [127:0] state_out0, state_out1, key_out0, key_out1;
  logic [7:0]   rcon_out0, rcon_out1;

  always #5 clock = ~clock;

  aes_subkey_pipe #(.PIPE_DEPTH(Depth), .RCON_AUTO(0)) u_dut_ext (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .state_in(state_in), .key_in(key_in), .rcon_in(rcon_in), .rcon_restart(rcon_restart),
`ifdef AES_INV_SBOX_EN
    .inv_in(inv_in),
`endif
    .out_valid(ov0), .out_ready(out_ready), .state_out(state_out0), .key_out(key_out0),
    .rcon_out(rcon_out0)
  );

  aes_subkey_pipe #(.PIPE_DEPTH(Depth), .RCON_AUTO(1)) u_dut_auto (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .state_in(state_in), .key_in(key_in), .rcon_in(rcon_in), .rcon_restart(rcon_restart),
`ifdef AES_INV_SBOX_EN
    .inv_in(inv_in),
`endif
    .out_valid(ov1), .out_ready(out_ready), .state_out(state_out1), .key_out(key_out1),
    .rcon_out(rcon_out1)
  );

  typedef struct {
    logic [127:0] st;
    logic [127:0] k0;
    logic [127:0] k1;
    logic [7:0]   r0;
    logic [7:0]   r1;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic         mon_en = 1'b0;
  logic [7:0]   rc_model = 8'h01;
  logic [127:0] st_pat [5];
  logic [127:0] st_exp [5];
  logic [127:0] rk [11];
  logic [7:0]   rc_tab [10];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Changing the Rcon by d flips byte 0 of every output word by d.
  function automatic logic [127:0] rep(input logic [7:0] d);
    return {d, 24'h0, d, 24'h0, d, 24'h0, d, 24'h0};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one beat until accepted; kref is the known next key for Rcon rref with this key_in.
  task automatic send_beat(input int pat, input logic [127:0] key, input logic [127:0] kref,
                           input logic [7:0] rref, input logic [7:0] rin, input logic restart);
    logic       acc;
    logic [7:0] r1;
    exp_t       e;
    int         waited;
    state_in = st_pat[pat];
    key_in = key;
    rcon_in = rin;
    rcon_restart = restart;
    in_valid = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 50) begin
      @(negedge clock);
      acc = in_ready0;
      @(posedge clock);
      #1;
      waited++;
    end
    check("accepted", 128'(acc), 128'(1));
    if (acc) begin
      r1 = restart ? 8'h01 : rc_model;
      rc_model = (r1 == 8'h36) ? 8'h01 : xt(r1);
      e.st = st_exp[pat];
      e.k0 = kref ^ rep(rin ^ rref);
      e.k1 = kref ^ rep(r1 ^ rref);
      e.r0 = xt(rin);
      e.r1 = xt(r1);
      sb.push_back(e);
    end
    in_valid = 1'b0;
    rcon_restart = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    check("drain_empty", 128'(sb.size()), 128'(0));
    @(posedge clock);
    #1;
  endtask

  // Output monitor: compare every transferred beat against the scoreboard head.
  always @(negedge clock) begin : mon
    exp_t e;
    if (mon_en && reset_n) begin
      check("valid_match", 128'(ov1), 128'(ov0));
      check("ready_match", 128'(in_ready1), 128'(in_ready0));
      if (ov0 && out_ready) begin
        n_checks++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat observed out_valid=1 expected no beat in flight");
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("state_ext", state_out0, e.st);
          check("key_ext", key_out0, e.k0);
          check("rcon_ext", 128'(rcon_out0), 128'(e.r0));
          check("state_auto", state_out1, e.st);
          check("key_auto", key_out1, e.k1);
          check("rcon_auto", 128'(rcon_out1), 128'(e.r1));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t0;
    st_pat[0] = 128'h000102030405060708090a0b0c0d0e0f;
    st_exp[0] = 128'h637c777bf26b6fc53001672bfed7ab76;
    st_pat[1] = {16{8'h53}};
    st_exp[1] = {16{8'hed}};
    st_pat[2] = 128'h101112131415161718191a1b1c1d1e1f;
    st_exp[2] = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    st_pat[3] = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    st_exp[3] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    st_pat[4] = {16{8'h63}};
`ifdef AES_INV_SBOX_EN
    st_exp[4] = '0;
`else
    st_exp[4] = {16{8'hfb}};
`endif
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_valid_ext", 128'(ov0), 128'(0));
    check("rst_valid_auto", 128'(ov1), 128'(0));
    check("rst_state", state_out0, 128'h0);
    check("rst_key", key_out1, 128'h0);
    check("rst_rcon_ext", 128'(rcon_out0), 128'(0));
    check("rst_rcon_auto", 128'(rcon_out1), 128'(0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    check("rel_in_ready", 128'(in_ready0), 128'(1));

    // Known-answer beat and exact latency
    @(posedge clock);
    #1;
    send_beat(0, rk[0], rk[1], 8'h01, 8'h01, 1'b0);
    @(negedge clock);
    check("lat_early", 128'(ov0), 128'(0));
    @(posedge clock);
    #1;
    @(negedge clock);
    check("lat_on_time", 128'(ov0), 128'(1));
    drain();

    // rcon_in ignored by the auto instance (its counter is at 0x02 now)
    send_beat(1, rk[0], rk[1], 8'h01, 8'h36, 1'b0);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send_beat(2, rk[0], rk[1], 8'h01, 8'h01, 1'b0);
    send_beat(3, rk[0], rk[1], 8'h01, 8'h02, 1'b0);
    reset_n = 1'b0;
    #1;
    check("flush_valid_ext", 128'(ov0), 128'(0));
    check("flush_valid_auto", 128'(ov1), 128'(0));
    sb.delete();
    rc_model = 8'h01;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("no_stale", 128'(ov0), 128'(0));
    end
    @(posedge clock);
    #1;

    // FIPS-197 key schedule, 11 back-to-back beats, Rcon wraps after 0x36
    t0 = 128'($time);
    for (int i = 0; i < 10; i++) begin
      send_beat(i % 4, rk[i], rk[i+1], rc_tab[i], rc_tab[i], 1'b0);
    end
    send_beat(0, rk[0], rk[1], 8'h01, 8'h01, 1'b0);
    check("throughput", 128'($time) - t0, 128'(110));
    drain();

    // Stall with a full pipe: head beat must hold, no acceptance
    out_ready = 1'b0;
    send_beat(0, rk[0], rk[1], 8'h01, 8'h8d, 1'b0);
    send_beat(1, rk[0], rk[1], 8'h01, 8'h80, 1'b0);
    state_in = st_pat[2];
    key_in = rk[0];
    rcon_in = 8'h36;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("stall_in_ready", 128'(in_ready0), 128'(0));
      check("stall_valid", 128'(ov0), 128'(1));
      check("stall_state", state_out0, sb[0].st);
      check("stall_key_ext", key_out0, sb[0].k0);
      check("stall_key_auto", key_out1, sb[0].k1);
      check("stall_rcon_auto", 128'(rcon_out1), 128'(sb[0].r1));
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    send_beat(2, rk[0], rk[1], 8'h01, 8'h36, 1'b0);
    send_beat(3, rk[0], rk[1], 8'h01, 8'h00, 1'b0);
    drain();

    // Restart on the 4th beat after reset; a restart without acceptance is ignored
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    rc_model = 8'h01;
    send_beat(0, rk[0], rk[1], 8'h01, 8'h01, 1'b0);
    send_beat(1, rk[0], rk[1], 8'h01, 8'h02, 1'b0);
    rcon_restart = 1'b1;
    rcon_in = 8'hff;
    @(posedge clock);
    #1;
    rcon_restart = 1'b0;
    send_beat(2, rk[0], rk[1], 8'h01, 8'h04, 1'b0);
    send_beat(3, rk[0], rk[1], 8'h01, 8'h01, 1'b1);
    send_beat(0, rk[0], rk[1], 8'h01, 8'h02, 1'b0);
    drain();

    // 0x63 through the state path (inverse S-box when enabled)
`ifdef AES_INV_SBOX_EN
    inv_in = 1'b1;
`endif
    send_beat(4, rk[0], rk[1], 8'h01, 8'h01, 1'b0);
`ifdef AES_INV_SBOX_EN
    inv_in = 1'b0;
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
